// File: rtl/voice_allocator.sv
// voice_allocator: spreads the song reader's note stream over VOICES playback voices and times each note in beats.
// Build option: define VOICE_STEAL_EN to overwrite the voice closest to expiry when every voice is busy.
module voice_allocator #(
  parameter int VOICES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play,
  input  logic                beat,
  input  logic                new_note,
  input  logic [5:0]          note,
  input  logic [5:0]          duration,
  input  logic [2:0]          metadata,
  output logic [6*VOICES-1:0] voice_note,
  output logic [3*VOICES-1:0] voice_meta,
  output logic [VOICES-1:0]   voice_active,
  output logic [VOICES-1:0]   voice_load,
  output logic                note_done,
  output logic                dropped
);

  logic [5:0]        r_note [VOICES];
  logic [2:0]        r_meta [VOICES];
  logic [5:0]        r_rem  [VOICES];
  logic [VOICES-1:0] r_active;
  logic [VOICES-1:0] r_load;
  logic              r_done;
  logic              r_dropped;

  logic              w_tick;
  logic              w_valid;
  logic              w_found;
  logic              w_drop;
  logic [VOICES-1:0] w_expire;
  logic [VOICES-1:0] w_free;
  logic [VOICES-1:0] w_first;
  logic [VOICES-1:0] w_sel;
`ifdef VOICE_STEAL_EN
  logic [VOICES-1:0] w_steal;
  logic [5:0]        w_min;
`endif

  always_comb begin
    w_tick   = beat & play;
    w_valid  = new_note & (duration != 6'd0);
    w_expire = '0;
    for (int i = 0; i < VOICES; i++)
      w_expire[i] = r_active[i] & w_tick & (r_rem[i] == 6'd1);
    // A voice expiring this cycle is free for a note arriving in the same cycle.
    w_free  = ~r_active | w_expire;
    w_first = '0;
    w_found = 1'b0;
    for (int i = 0; i < VOICES; i++) begin
      if (w_free[i] && !w_found) begin
        w_first[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
`ifdef VOICE_STEAL_EN
    w_steal    = '0;
    w_steal[0] = 1'b1;
    w_min      = r_rem[0];
    for (int i = 1; i < VOICES; i++) begin
      if (r_rem[i] < w_min) begin
        w_steal    = '0;
        w_steal[i] = 1'b1;
        w_min      = r_rem[i];
      end
    end
    w_sel = !w_valid ? '0 : (w_found ? w_first : w_steal);
`else
    w_sel = (w_valid && w_found) ? w_first : '0;
`endif
    w_drop = new_note & ~(|w_sel);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < VOICES; i++) begin
        r_note[i] <= '0;
        r_meta[i] <= '0;
        r_rem[i]  <= '0;
      end
      r_active  <= '0;
      r_load    <= '0;
      r_done    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        // A load takes priority over counting, so a fresh note keeps its full duration.
        if (w_sel[i]) begin
          r_note[i]   <= note;
          r_meta[i]   <= metadata;
          r_rem[i]    <= duration;
          r_active[i] <= 1'b1;
        end else if (w_tick && r_active[i]) begin
          if (r_rem[i] == 6'd1)
            r_active[i] <= 1'b0;
          else
            r_rem[i] <= r_rem[i] - 6'd1;
        end
      end
      r_load    <= w_sel;
      r_done    <= |w_expire;
      r_dropped <= w_drop;
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_out
    assign voice_note[6*g +: 6] = r_note[g];
    assign voice_meta[3*g +: 3] = r_meta[g];
  end

  assign voice_active = r_active;
  assign voice_load   = r_load;
  assign note_done    = r_done;
  assign dropped      = r_dropped;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: per-scenario stimulus tables with a scoreboard of expected outputs.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        play = 1'b0;
  logic        beat = 1'b0;
  logic        new_note = 1'b0;
  logic [5:0]  note = '0;
  logic [5:0]  duration = '0;
  logic [2:0]  metadata = '0;
  logic [17:0] voice_note;
  logic [8:0]  voice_meta;
  logic [2:0]  voice_active;
  logic [2:0]  voice_load;
  logic        note_done;
  logic        dropped;

  int n_pass = 0;
  int n_total = 0;

  // ef = {voice_load, voice_active, note_done, dropped}; en checked only when nc is set
  typedef struct packed {
    logic        nn;
    logic [5:0]  n;
    logic [5:0]  d;
    logic [2:0]  m;
    logic        bt;
    logic        pl;
    logic [7:0]  ef;
    logic        nc;
    logic [17:0] en;
  } step_t;

  typedef struct packed {
    logic [7:0]  ef;
    logic        nc;
    logic [17:0] en;
  } exp_t;

  exp_t sb[$];

  voice_allocator dut (
    .clk(clk), .reset(reset), .play(play), .beat(beat), .new_note(new_note),
    .note(note), .duration(duration), .metadata(metadata),
    .voice_note(voice_note), .voice_meta(voice_meta), .voice_active(voice_active),
    .voice_load(voice_load), .note_done(note_done), .dropped(dropped)
  );

  always #5 clk = ~clk;

  function automatic step_t S(input logic nn, input logic [5:0] n, input logic [5:0] d,
                              input logic [2:0] m, input logic bt, input logic pl,
                              input logic [7:0] ef, input logic nc, input logic [17:0] en);
    return '{nn: nn, n: n, d: d, m: m, bt: bt, pl: pl, ef: ef, nc: nc, en: en};
  endfunction

  task automatic drive(input step_t s);
    new_note = s.nn; note = s.n; duration = s.d; metadata = s.m; beat = s.bt; play = s.pl;
    @(posedge clk); #1;
    new_note = 1'b0; beat = 1'b0;
  endtask

  task automatic apply_reset();
    new_note = 1'b0; beat = 1'b0; play = 1'b1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if ({voice_note, voice_meta, voice_active, voice_load, note_done, dropped} !== 35'd0)
      $display("FAIL reset_state: got %h expected 0",
               {voice_note, voice_meta, voice_active, voice_load, note_done, dropped});
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_single();
    step_t tbl[$];
    exp_t e;
    apply_reset();
    tbl.push_back(S(1, 20, 3, 5, 0, 1, 8'b001_001_0_0, 1, {6'd0, 6'd0, 6'd20}));
    tbl.push_back(S(0, 0, 0, 0, 1, 1, 8'b000_001_0_0, 0, 18'd0));
    tbl.push_back(S(0, 0, 0, 0, 1, 1, 8'b000_001_0_0, 0, 18'd0));
    tbl.push_back(S(0, 0, 0, 0, 1, 1, 8'b000_000_1_0, 0, 18'd0));
    tbl.push_back(S(0, 0, 0, 0, 0, 1, 8'b000_000_0_0, 1, {6'd0, 6'd0, 6'd20}));
    foreach (tbl[k]) begin
      sb.push_back('{ef: tbl[k].ef, nc: tbl[k].nc, en: tbl[k].en});
      drive(tbl[k]);
      e = sb.pop_front();
      n_total++;
      if ({voice_load, voice_active, note_done, dropped} !== e.ef || (e.nc && voice_note !== e.en))
        $display("FAIL single[%0d]: got flags=%b notes=%h, expected flags=%b notes=%h",
                 k, {voice_load, voice_active, note_done, dropped}, voice_note, e.ef, e.en);
      else n_pass++;
    end
    n_total++;
    if (voice_meta !== 9'd5) $display("FAIL single_meta_hold: got %h expected %h", voice_meta, 9'd5);
    else n_pass++;
  endtask

  task automatic test_chord();
    step_t tbl[$];
    exp_t e;
    apply_reset();
    tbl.push_back(S(1, 10, 4, 1, 0, 1, 8'b001_001_0_0, 1, {6'd0, 6'd0, 6'd10}));
    tbl.push_back(S(1, 14, 4, 2, 0, 1, 8'b010_011_0_0, 1, {6'd0, 6'd14, 6'd10}));
    tbl.push_back(S(1, 17, 4, 3, 0, 1, 8'b100_111_0_0, 1, {6'd17, 6'd14, 6'd10}));
    for (int i = 0; i < 3; i++) tbl.push_back(S(0, 0, 0, 0, 1, 1, 8'b000_111_0_0, 0, 18'd0));
    tbl.push_back(S(0, 0, 0, 0, 1, 1, 8'b000_000_1_0, 0, 18'd0));
    tbl.push_back(S(0, 0, 0, 0, 0, 1, 8'b000_000_0_0, 0, 18'd0));
    foreach (tbl[k]) begin
      sb.push_back('{ef: tbl[k].ef, nc: tbl[k].nc, en: tbl[k].en});
      drive(tbl[k]);
      e = sb.pop_front();
      n_total++;
      if ({voice_load, voice_active, note_done, dropped} !== e.ef || (e.nc && voice_note !== e.en))
        $display("FAIL chord[%0d]: got flags=%b notes=%h, expected flags=%b notes=%h",
                 k, {voice_load, voice_active, note_done, dropped}, voice_note, e.ef, e.en);
      else n_pass++;
    end
    n_total++;
    if (voice_meta !== {3'd3, 3'd2, 3'd1})
      $display("FAIL chord_meta: got %h expected %h", voice_meta, {3'd3, 3'd2, 3'd1});
    else n_pass++;
  endtask

  task automatic test_overflow();
    step_t tbl[$];
    exp_t e;
    apply_reset();
    tbl.push_back(S(1, 1, 5, 0, 0, 1, 8'b001_001_0_0, 0, 18'd0));
    tbl.push_back(S(1, 2, 2, 0, 0, 1, 8'b010_011_0_0, 0, 18'd0));
    tbl.push_back(S(1, 3, 7, 0, 0, 1, 8'b100_111_0_0, 1, {6'd3, 6'd2, 6'd1}));
`ifdef VOICE_STEAL_EN
    tbl.push_back(S(1, 22, 2, 0, 0, 1, 8'b010_111_0_0, 1, {6'd3, 6'd22, 6'd1}));
`else
    tbl.push_back(S(1, 22, 2, 0, 0, 1, 8'b000_111_0_1, 1, {6'd3, 6'd2, 6'd1}));
`endif
    tbl.push_back(S(0, 0, 0, 0, 1, 1, 8'b000_111_0_0, 0, 18'd0));
    tbl.push_back(S(0, 0, 0, 0, 1, 1, 8'b000_101_1_0, 0, 18'd0));
    tbl.push_back(S(0, 0, 0, 0, 0, 1, 8'b000_101_0_0, 0, 18'd0));
    foreach (tbl[k]) begin
      sb.push_back('{ef: tbl[k].ef, nc: tbl[k].nc, en: tbl[k].en});
      drive(tbl[k]);
      e = sb.pop_front();
      n_total++;
      if ({voice_load, voice_active, note_done, dropped} !== e.ef || (e.nc && voice_note !== e.en))
        $display("FAIL overflow[%0d]: got flags=%b notes=%h, expected flags=%b notes=%h",
                 k, {voice_load, voice_active, note_done, dropped}, voice_note, e.ef, e.en);
      else n_pass++;
    end
  endtask

  task automatic test_pause();
    step_t tbl[$];
    exp_t e;
    apply_reset();
    tbl.push_back(S(1, 9, 2, 0, 0, 1, 8'b001_001_0_0, 1, {6'd0, 6'd0, 6'd9}));
    tbl.push_back(S(0, 0, 0, 0, 1, 1, 8'b000_001_0_0, 0, 18'd0));
    for (int i = 0; i < 5; i++) tbl.push_back(S(0, 0, 0, 0, 1, 0, 8'b000_001_0_0, 0, 18'd0));
    tbl.push_back(S(1, 11, 1, 0, 1, 0, 8'b010_011_0_0, 1, {6'd0, 6'd11, 6'd9}));
    tbl.push_back(S(0, 0, 0, 0, 1, 1, 8'b000_000_1_0, 0, 18'd0));
    tbl.push_back(S(0, 0, 0, 0, 0, 1, 8'b000_000_0_0, 0, 18'd0));
    foreach (tbl[k]) begin
      sb.push_back('{ef: tbl[k].ef, nc: tbl[k].nc, en: tbl[k].en});
      drive(tbl[k]);
      e = sb.pop_front();
      n_total++;
      if ({voice_load, voice_active, note_done, dropped} !== e.ef || (e.nc && voice_note !== e.en))
        $display("FAIL pause[%0d]: got flags=%b notes=%h, expected flags=%b notes=%h",
                 k, {voice_load, voice_active, note_done, dropped}, voice_note, e.ef, e.en);
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    step_t tbl[$];
    exp_t e;
    apply_reset();
    tbl.push_back(S(1, 8, 2, 0, 0, 1, 8'b001_001_0_0, 1, {6'd0, 6'd0, 6'd8}));
    tbl.push_back(S(0, 0, 0, 0, 1, 1, 8'b000_001_0_0, 0, 18'd0));
    tbl.push_back(S(1, 30, 5, 6, 1, 1, 8'b001_001_1_0, 1, {6'd0, 6'd0, 6'd30}));
    for (int i = 0; i < 4; i++) tbl.push_back(S(0, 0, 0, 0, 1, 1, 8'b000_001_0_0, 0, 18'd0));
    tbl.push_back(S(0, 0, 0, 0, 1, 1, 8'b000_000_1_0, 0, 18'd0));
    tbl.push_back(S(0, 0, 0, 0, 0, 1, 8'b000_000_0_0, 0, 18'd0));
    foreach (tbl[k]) begin
      sb.push_back('{ef: tbl[k].ef, nc: tbl[k].nc, en: tbl[k].en});
      drive(tbl[k]);
      e = sb.pop_front();
      n_total++;
      if ({voice_load, voice_active, note_done, dropped} !== e.ef || (e.nc && voice_note !== e.en))
        $display("FAIL collision[%0d]: got flags=%b notes=%h, expected flags=%b notes=%h",
                 k, {voice_load, voice_active, note_done, dropped}, voice_note, e.ef, e.en);
      else n_pass++;
    end
  endtask

  task automatic test_dur_zero();
    step_t tbl[$];
    exp_t e;
    apply_reset();
    tbl.push_back(S(1, 12, 0, 1, 0, 1, 8'b000_000_0_1, 1, 18'd0));
    tbl.push_back(S(0, 0, 0, 0, 0, 1, 8'b000_000_0_0, 1, 18'd0));
    tbl.push_back(S(1, 13, 1, 1, 0, 1, 8'b001_001_0_0, 1, {6'd0, 6'd0, 6'd13}));
    tbl.push_back(S(1, 14, 0, 1, 0, 1, 8'b000_001_0_1, 1, {6'd0, 6'd0, 6'd13}));
    foreach (tbl[k]) begin
      sb.push_back('{ef: tbl[k].ef, nc: tbl[k].nc, en: tbl[k].en});
      drive(tbl[k]);
      e = sb.pop_front();
      n_total++;
      if ({voice_load, voice_active, note_done, dropped} !== e.ef || (e.nc && voice_note !== e.en))
        $display("FAIL dur_zero[%0d]: got flags=%b notes=%h, expected flags=%b notes=%h",
                 k, {voice_load, voice_active, note_done, dropped}, voice_note, e.ef, e.en);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(S(1, 7, 3, 2, 0, 1, 8'b0, 0, 18'd0));
    n_total++;
    if ({voice_load, voice_active, note_done, dropped} !== 8'b001_001_0_0)
      $display("FAIL async_pre: got %b expected %b", {voice_load, voice_active, note_done, dropped}, 8'b001_001_0_0);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++;
    if ({voice_note, voice_meta, voice_active, voice_load, note_done, dropped} !== 35'd0)
      $display("FAIL async_clear: got %h expected 0",
               {voice_note, voice_meta, voice_active, voice_load, note_done, dropped});
    else n_pass++;
    beat = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(S(0, 0, 0, 0, 1, 1, 8'b0, 0, 18'd0));
      n_total++;
      if ({voice_load, voice_active, note_done, dropped} !== 8'b0)
        $display("FAIL async_after[%0d]: got %b expected %b", i, {voice_load, voice_active, note_done, dropped}, 8'b0);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_chord();
    test_overflow();
    test_pause();
    test_collision();
    test_dur_zero();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
